aixh_mxc_left_qctrl: RTL and testbench

Command sequencer for the MxConv left queue column, i.e. the chain of left queue-tiles fed by a single vertical enable/mode bus. It accepts load and replay commands and drives the column-top write enable, read enable and read mode. It counts rows and replay passes, applies input-side flow control and output-side stall, and waits a fixed drain interval before signalling completion. It sits between the MxC command decoder and the top of the left queue column.

---
 rtl/aixh_mxc_left_qctrl.sv | 169 ++++++++++++++++
 tb/tb_aixh_mxc_left_qctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/aixh_mxc_left_qctrl.sv
// Command sequencer for the MxConv left queue column: turns load/replay commands
// into column-top write/read enables with row/pass counting, flow control and a drain wait.
module aixh_mxc_left_qctrl #(
    parameter int ROW_CNT_W    = 8,
    parameter int PASS_CNT_W   = 8,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                  aixh_core_clk,
    input  logic                  aixh_core_rstn,
    input  logic                  i_cmd_vld,
    output logic                  o_cmd_rdy,
    input  logic [1:0]            i_cmd_op,
    input  logic [ROW_CNT_W-1:0]  i_cmd_rows,
    input  logic [PASS_CNT_W-1:0] i_cmd_passes,
    input  logic [1:0]            i_cmd_rmode,
    input  logic                  i_wr_vld,
    output logic                  o_wr_rdy,
    input  logic                  i_rd_stall,
    output logic                  o_iwenable,
    output logic                  o_irenable,
    output logic [1:0]            o_irmode,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam logic [1:0] OP_WRITE      = 2'd0;
    localparam logic [1:0] OP_READ       = 2'd1;
    localparam logic [1:0] OP_WRITE_READ = 2'd2;
    localparam logic [1:0] OP_ILLEGAL    = 2'd3;
    localparam logic [7:0] DRAIN_LAST    = 8'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [ROW_CNT_W-1:0]    row_cnt, row_cnt_nxt;
    logic [ROW_CNT_W-1:0]    rows_q, rows_nxt;
    logic [PASS_CNT_W-1:0]   pass_cnt, pass_cnt_nxt;
    logic [PASS_CNT_W-1:0]   passes_q, passes_nxt;
    logic [7:0]              drain_cnt, drain_cnt_nxt;
    logic [1:0]              op_q, op_nxt;
    logic [1:0]              rmode_q, rmode_nxt;
    logic                    iwen_nxt, iren_nxt, done_nxt, err_nxt;

    assign o_cmd_rdy = (state == ST_IDLE);
    assign o_wr_rdy  = (state == ST_WRITE);
    assign o_irmode  = rmode_q;

    always_comb begin
        state_nxt     = state;
        row_cnt_nxt   = row_cnt;
        pass_cnt_nxt  = pass_cnt;
        drain_cnt_nxt = drain_cnt;
        rows_nxt      = rows_q;
        passes_nxt    = passes_q;
        op_nxt        = op_q;
        rmode_nxt     = rmode_q;
        iwen_nxt      = 1'b0;
        iren_nxt      = 1'b0;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_cmd_vld) begin
                    // An illegal op is flagged but leaves every latched field untouched
                    if (i_cmd_op == OP_ILLEGAL) begin
                        err_nxt = 1'b1;
                    end else begin
                        rows_nxt     = i_cmd_rows;
                        passes_nxt   = i_cmd_passes;
                        rmode_nxt    = i_cmd_rmode;
                        op_nxt       = i_cmd_op;
                        row_cnt_nxt  = '0;
                        pass_cnt_nxt = '0;
                        state_nxt    = (i_cmd_op == OP_READ) ? ST_READ : ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                if (i_wr_vld) begin
                    iwen_nxt = 1'b1;
                    if (row_cnt == rows_q) begin
                        row_cnt_nxt = '0;
                        state_nxt   = (op_q == OP_WRITE_READ) ? ST_READ : ST_DRAIN;
                    end else begin
                        row_cnt_nxt = row_cnt + ROW_CNT_W'(1);
                    end
                end
            end

            ST_READ: begin
                if (!i_rd_stall) begin
                    iren_nxt = 1'b1;
                    // Row counter wraps per pass; the final row of the final pass ends the replay
                    if (row_cnt == rows_q) begin
                        row_cnt_nxt = '0;
                        if (pass_cnt == passes_q) begin
                            pass_cnt_nxt = '0;
                            state_nxt    = ST_DRAIN;
                        end else begin
                            pass_cnt_nxt = pass_cnt + PASS_CNT_W'(1);
                        end
                    end else begin
                        row_cnt_nxt = row_cnt + ROW_CNT_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    drain_cnt_nxt = '0;
                    done_nxt      = 1'b1;
                    state_nxt     = ST_DONE;
                end else begin
                    drain_cnt_nxt = drain_cnt + 8'd1;
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aixh_core_clk) begin
        if (!aixh_core_rstn) begin
            state      <= ST_IDLE;
            row_cnt    <= '0;
            pass_cnt   <= '0;
            drain_cnt  <= '0;
            rows_q     <= '0;
            passes_q   <= '0;
            op_q       <= '0;
            rmode_q    <= '0;
            o_iwenable <= 1'b0;
            o_irenable <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state      <= state_nxt;
            row_cnt    <= row_cnt_nxt;
            pass_cnt   <= pass_cnt_nxt;
            drain_cnt  <= drain_cnt_nxt;
            rows_q     <= rows_nxt;
            passes_q   <= passes_nxt;
            op_q       <= op_nxt;
            rmode_q    <= rmode_nxt;
            o_iwenable <= iwen_nxt;
            o_irenable <= iren_nxt;
            o_busy     <= (state_nxt != ST_IDLE);
            o_done     <= done_nxt;
            o_err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_aixh_mxc_left_qctrl.sv
// Scoreboard bench for aixh_mxc_left_qctrl: directed commands push expected
// enable/done/err events; a negedge monitor pops and compares each one.
module tb_aixh_mxc_left_qctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_vld = 1'b0;
    logic       cmd_rdy;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_rows = 8'd0;
    logic [7:0] cmd_passes = 8'd0;
    logic [1:0] cmd_rmode = 2'd0;
    logic       wr_vld = 1'b0;
    logic       wr_rdy;
    logic       rd_stall = 1'b0;
    logic       iwen, iren, busy, done, err;
    logic [1:0] irmode;

    always #5 clk = ~clk;

    aixh_mxc_left_qctrl #(
        .ROW_CNT_W   (8),
        .PASS_CNT_W  (8),
        .DRAIN_CYCLES(16)
    ) dut (
        .aixh_core_clk (clk),
        .aixh_core_rstn(rstn),
        .i_cmd_vld     (cmd_vld),
        .o_cmd_rdy     (cmd_rdy),
        .i_cmd_op      (cmd_op),
        .i_cmd_rows    (cmd_rows),
        .i_cmd_passes  (cmd_passes),
        .i_cmd_rmode   (cmd_rmode),
        .i_wr_vld      (wr_vld),
        .o_wr_rdy      (wr_rdy),
        .i_rd_stall    (rd_stall),
        .o_iwenable    (iwen),
        .o_irenable    (iren),
        .o_irmode      (irmode),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err)
    );

    typedef struct {
        int         cyc;
        logic       iw;
        logic       ir;
        logic       dn;
        logic       er;
        logic [1:0] rm;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic iw, input logic ir, input logic dn,
                        input logic er, input logic [1:0] rm);
        ev_t e;
        e.cyc = c; e.iw = iw; e.ir = ir; e.dn = dn; e.er = er; e.rm = rm;
        exp_q.push_back(e);
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [7:0] rows,
                             input logic [7:0] passes, input logic [1:0] rm, output int t);
        @(posedge clk); #1;
        chk("cmd_rdy_before_cmd", 32'(cmd_rdy), 32'd1);
        cmd_vld = 1'b1; cmd_op = op; cmd_rows = rows; cmd_passes = passes; cmd_rmode = rm;
        t = cyc;
        @(posedge clk); #1;
        cmd_vld = 1'b0;
    endtask

    // Monitor: every cycle showing an enable, done or err must match the next expected event
    always @(negedge clk) begin
        if (iwen | iren | done | err) begin
            checks++;
            if (iwen && iren) begin
                errors++;
                $display("FAIL enable_overlap at cycle %0d: iwen and iren both high", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL event at cycle %0d: got iwen=%b iren=%b done=%b err=%b rmode=%0d, expected no event",
                         cyc, iwen, iren, done, err, irmode);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || {iwen, iren, done, err, irmode} !==
                    {mon_e.iw, mon_e.ir, mon_e.dn, mon_e.er, mon_e.rm}) begin
                    errors++;
                    $display("FAIL event at cycle %0d: got iwen=%b iren=%b done=%b err=%b rmode=%0d, expected cycle %0d iwen=%b iren=%b done=%b err=%b rmode=%0d",
                             cyc, iwen, iren, done, err, irmode,
                             mon_e.cyc, mon_e.iw, mon_e.ir, mon_e.dn, mon_e.er, mon_e.rm);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t2;
        logic pat [5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("rst_outputs", 32'({wr_rdy, iwen, iren, busy, done, err, irmode}), 32'd0);
        rstn = 1'b1;

        // 1: WRITE rows=3, wr_vld constant
        wr_vld = 1'b1;
        issue_cmd(2'd0, 8'd3, 8'd0, 2'd1, t);
        for (int k = 2; k <= 5; k++) push(t + k, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        push(t + 21, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        chk("t1_wr_rdy_first", 32'(wr_rdy), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_irmode", 32'(irmode), 32'd1);
        at_cyc(t + 4);
        chk("t1_wr_rdy_last", 32'(wr_rdy), 32'd1);
        at_cyc(t + 5);
        chk("t1_wr_rdy_drain", 32'(wr_rdy), 32'd0);
        chk("t1_cmd_rdy_drain", 32'(cmd_rdy), 32'd0);
        at_cyc(t + 21);
        chk("t1_cmd_rdy_done", 32'(cmd_rdy), 32'd0);
        at_cyc(t + 22);
        chk("t1_cmd_rdy_idle", 32'(cmd_rdy), 32'd1);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        wr_vld = 1'b0;

        // 2: READ rows=1 passes=2 rmode=2, no stall
        issue_cmd(2'd1, 8'd1, 8'd2, 2'd2, t);
        for (int k = 2; k <= 7; k++) push(t + k, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        push(t + 23, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        chk("t2_irmode", 32'(irmode), 32'd2);
        chk("t2_wr_rdy", 32'(wr_rdy), 32'd0);
        at_cyc(t + 24);
        chk("t2_cmd_rdy_idle", 32'(cmd_rdy), 32'd1);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3: as 2 with stall on alternate cycles
        issue_cmd(2'd1, 8'd1, 8'd2, 2'd2, t);
        for (int k = 3; k <= 13; k += 2) push(t + k, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        push(t + 29, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        for (int k = 1; k <= 14; k++) begin
            rd_stall = (k % 2 == 1);
            @(posedge clk); #1;
        end
        rd_stall = 1'b0;
        at_cyc(t + 30);
        chk("t3_cmd_rdy_idle", 32'(cmd_rdy), 32'd1);
        chk("t3_irmode", 32'(irmode), 32'd2);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4: WRITE_READ rows=2 passes=0, wr_vld 1,0,0,1,1
        issue_cmd(2'd2, 8'd2, 8'd0, 2'd3, t);
        push(t + 2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        push(t + 5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        push(t + 6, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        for (int k = 7; k <= 9; k++) push(t + k, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        push(t + 25, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
        for (int k = 0; k < 5; k++) begin
            wr_vld = pat[k];
            @(posedge clk); #1;
        end
        wr_vld = 1'b0;
        chk("t4_wr_rdy_read", 32'(wr_rdy), 32'd0);
        at_cyc(t + 26);
        chk("t4_cmd_rdy_idle", 32'(cmd_rdy), 32'd1);
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: illegal op, then a legal READ rows=0 passes=0
        issue_cmd(2'd3, 8'd5, 8'd5, 2'd0, t);
        push(t + 1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("t5_irmode_kept", 32'(irmode), 32'd3);
        issue_cmd(2'd1, 8'd0, 8'd0, 2'd1, t2);
        push(t2 + 2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        push(t2 + 18, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        at_cyc(t2 + 19);
        chk("t5_cmd_rdy_idle", 32'(cmd_rdy), 32'd1);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: reset during READ after two reads
        issue_cmd(2'd1, 8'd1, 8'd2, 2'd0, t);
        push(t + 2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        push(t + 3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        at_cyc(t + 2);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("t6_rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("t6_rst_outputs", 32'({wr_rdy, iwen, iren, busy, done, err, irmode}), 32'd0);
        rstn = 1'b1;
        issue_cmd(2'd1, 8'd1, 8'd2, 2'd2, t);
        for (int k = 2; k <= 7; k++) push(t + k, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        push(t + 23, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        at_cyc(t + 24);
        chk("t6_cmd_rdy_idle", 32'(cmd_rdy), 32'd1);
        at_cyc(t + 30);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
